// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: per-frame acquire/track/hold/search steering controller.
// One signed multiplier is time-shared between the P and D terms.
module line_follow_ctrl #(
  parameter int IMG_W = 640,
  parameter logic signed [7:0] KP = 8'sd16,
  parameter logic signed [7:0] KD = 8'sd0,
  parameter int STEER_W = 12,
  parameter int ACQUIRE_FRAMES = 3,
  parameter int LOST_FRAMES = 8,
  parameter int SEARCH_STEER = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [$clog2(IMG_W)-1:0]  centroid_x,
  input  logic                      line_valid,
  input  logic                      line_lost,
  output logic signed [STEER_W-1:0] steer_out,
  output logic                      steer_valid,
  output logic [1:0]                mode,
  output logic                      motor_en,
  output logic                      busy,
  output logic                      overrun
);
  localparam int X_W = $clog2(IMG_W);
  localparam int E_W = X_W + 1;
  localparam int D_W = X_W + 2;
  localparam int P_W = 8 + D_W;
  localparam int S_W = X_W + 11;
  localparam int AW  = $clog2(ACQUIRE_FRAMES + 1);
  localparam int LW  = $clog2(LOST_FRAMES + 1);

  localparam logic [AW-1:0] ACQ_N  = AW'(ACQUIRE_FRAMES);
  localparam logic [LW-1:0] LOST_N = LW'(LOST_FRAMES);
  localparam logic signed [E_W-1:0] CX = E_W'(IMG_W / 2);
  localparam logic signed [S_W-1:0] SAT_P =
    S_W'((1 << (STEER_W - 1)) - 1);
  localparam logic signed [S_W-1:0] SAT_N = -SAT_P;
  localparam logic signed [STEER_W-1:0] SRCH =
    STEER_W'(SEARCH_STEER);

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_TRK  = 2'd1,
    ST_HOLD = 2'd2,
    ST_SRCH = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     r_mode;
  logic [AW-1:0]              r_acq;
  logic [LW-1:0]              r_lost;
  logic signed [E_W-1:0]      r_prev;
  logic signed [E_W-1:0]      r_err;
  logic signed [D_W-1:0]      r_d;
  logic [2:0]                 r_stg;
  logic signed [S_W-1:0]      r_acc;
  logic signed [STEER_W-1:0]  r_steer;
  logic                       r_sv;
  logic                       r_men;
  logic                       r_busy;
  logic                       r_ovr;

  state_t                     w_state_nxt;
  logic [AW-1:0]              w_acq_nxt;
  logic [LW-1:0]              w_lost_nxt;
  logic                       w_zero_d;
  logic                       w_accept;
  logic signed [E_W-1:0]      w_err;
  logic signed [D_W-1:0]      w_d;
  logic signed [7:0]          w_mul_a;
  logic signed [D_W-1:0]      w_mul_b;
  logic signed [P_W-1:0]      w_prod;
  logic signed [S_W-1:0]      w_shift;
  logic signed [STEER_W-1:0]  w_pd;
  logic signed [STEER_W-1:0]  w_steer_nxt;

  assign w_accept = line_valid & ~r_busy;
  assign w_err    = $signed({1'b0, centroid_x}) - CX;
  assign w_d      = w_zero_d ? '0
                  : D_W'(w_err) - D_W'(r_prev);

  // Mode FSM: the transition is fixed at the accept cycle
  always_comb begin
    w_state_nxt = r_state;
    w_acq_nxt   = r_acq;
    w_lost_nxt  = r_lost;
    w_zero_d    = 1'b0;
    if (w_accept) begin
      unique case (r_state)
        ST_ACQ: begin
          if (line_lost) begin
            w_acq_nxt = '0;
          end else if (r_acq + 1'b1 == ACQ_N) begin
            w_state_nxt = ST_TRK;
            w_acq_nxt   = '0;
            w_zero_d    = 1'b1;
          end else begin
            w_acq_nxt = r_acq + 1'b1;
          end
        end
        ST_TRK: begin
          if (line_lost) begin
            if (LOST_N == LW'(1)) begin
              w_state_nxt = ST_SRCH;
              w_lost_nxt  = '0;
            end else begin
              w_state_nxt = ST_HOLD;
              w_lost_nxt  = LW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!line_lost) begin
            w_state_nxt = ST_TRK;
            w_lost_nxt  = '0;
          end else if (r_lost + 1'b1 == LOST_N) begin
            w_state_nxt = ST_SRCH;
            w_lost_nxt  = '0;
          end else begin
            w_lost_nxt = r_lost + 1'b1;
          end
        end
        ST_SRCH: begin
          if (!line_lost) begin
            if (ACQ_N == AW'(1)) begin
              w_state_nxt = ST_TRK;
              w_zero_d    = 1'b1;
            end else begin
              w_state_nxt = ST_ACQ;
              w_acq_nxt   = AW'(1);
            end
          end
        end
      endcase
    end
  end

  assign w_mul_a = (r_stg == 3'd1) ? KP : KD;
  assign w_mul_b = (r_stg == 3'd1) ? D_W'(r_err) : r_d;
  assign w_prod  = w_mul_a * w_mul_b;
  assign w_shift = r_acc >>> 4;

  always_comb begin
    w_pd = w_shift[STEER_W-1:0];
    if (w_shift > SAT_P) begin
      w_pd = SAT_P[STEER_W-1:0];
    end else if (w_shift < SAT_N) begin
      w_pd = SAT_N[STEER_W-1:0];
    end
  end

  always_comb begin
    w_steer_nxt = '0;
    unique case (r_state)
      ST_ACQ:  w_steer_nxt = '0;
      ST_TRK:  w_steer_nxt = w_pd;
      ST_HOLD: w_steer_nxt = r_steer;
      ST_SRCH: w_steer_nxt = r_prev[E_W-1] ? -SRCH : SRCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACQ;
      r_mode  <= ST_ACQ;
      r_acq   <= '0;
      r_lost  <= '0;
      r_prev  <= '0;
      r_err   <= '0;
      r_d     <= '0;
      r_stg   <= '0;
      r_acc   <= '0;
      r_steer <= '0;
      r_sv    <= 1'b0;
      r_men   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acq   <= w_acq_nxt;
      r_lost  <= w_lost_nxt;
      r_sv    <= 1'b0;
      if (line_valid && r_busy) begin
        r_ovr <= 1'b1;
      end
      if (w_accept) begin
        r_busy <= 1'b1;
        r_stg  <= 3'd1;
        r_err  <= w_err;
        r_d    <= w_d;
        if (!line_lost) begin
          r_prev <= w_err;
        end
      end else if (r_busy) begin
        r_stg <= r_stg + 3'd1;
        case (r_stg)
          3'd1: r_acc <= S_W'(w_prod);
          3'd2: r_acc <= r_acc + S_W'(w_prod);
          3'd3: begin
            r_steer <= w_steer_nxt;
            r_mode  <= r_state;
            r_men   <= (r_state == ST_TRK) ||
                       (r_state == ST_HOLD);
            r_sv    <= 1'b1;
          end
          default: begin
            r_busy <= 1'b0;
            r_stg  <= '0;
          end
        endcase
      end
    end
  end

  assign steer_out   = r_steer;
  assign steer_valid = r_sv;
  assign mode        = r_mode;
  assign motor_en    = r_men;
  assign busy        = r_busy;
  assign overrun     = r_ovr;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// tb_line_follow_ctrl: scoreboard bench, two gain sets on shared stimulus.
// Expected results come from a frame-level reference model.
module tb_line_follow_ctrl;
  localparam int AF = 3;
  localparam int LF = 8;
  localparam int SMAX = 2047;

  typedef struct {
    int st; int acq; int lost; int prev; int steer;
  } mdl_t;
  typedef struct {
    int steer; int mode; int men; int due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] centroid_x = '0;
  logic line_valid = 1'b0;
  logic line_lost = 1'b0;

  logic signed [11:0] so0, so1;
  logic sv0, sv1, me0, me1, bz0, bz1, ov0, ov1;
  logic [1:0] md0, md1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  mdl_t m0, m1;
  exp_t q0[$], q1[$];
  exp_t p0, p1;

  line_follow_ctrl #(.KP(8'sd16), .KD(8'sd8)) dut0 (
    .clk(clk), .rst(rst), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost),
    .steer_out(so0), .steer_valid(sv0), .mode(md0),
    .motor_en(me0), .busy(bz0), .overrun(ov0));

  line_follow_ctrl #(.KP(8'sd127), .KD(8'sd0)) dut1 (
    .clk(clk), .rst(rst), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost),
    .steer_out(so1), .steer_valid(sv1), .mode(md1),
    .motor_en(me1), .busy(bz1), .overrun(ov1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level reference: states 0 ACQ, 1 TRK, 2 HOLD, 3 SRCH
  task automatic mstep(input mdl_t mi, input bit lst,
                       input int x, input int kp, input int kd,
                       input int due,
                       output mdl_t mo, output exp_t e);
    int err, d, pd;
    bit to_trk;
    mo = mi;
    err = x - 320;
    d = 0;
    to_trk = 0;
    if (lst) begin
      case (mi.st)
        0: mo.acq = 0;
        1: begin
          mo.lost = 1;
          mo.st = (LF == 1) ? 3 : 2;
        end
        2: begin
          mo.lost = mi.lost + 1;
          if (mo.lost >= LF) mo.st = 3;
        end
        default: ;
      endcase
    end else begin
      case (mi.st)
        0: begin
          mo.acq = mi.acq + 1;
          if (mo.acq >= AF) begin
            mo.st = 1; mo.acq = 0; to_trk = 1;
          end
        end
        2: begin mo.st = 1; mo.lost = 0; end
        3: begin
          mo.acq = 1;
          if (AF <= 1) begin mo.st = 1; to_trk = 1; end
          else mo.st = 0;
        end
        default: ;
      endcase
      d = to_trk ? 0 : err - mi.prev;
      mo.prev = err;
    end
    case (mo.st)
      0: mo.steer = 0;
      1: begin
        pd = (kp * err + kd * d) >>> 4;
        if (pd > SMAX) pd = SMAX;
        if (pd < -SMAX) pd = -SMAX;
        mo.steer = pd;
      end
      2: mo.steer = mi.steer;
      default: mo.steer = (mo.prev >= 0) ? 512 : -512;
    endcase
    e.steer = mo.steer;
    e.mode = mo.st;
    e.men = (mo.st == 1 || mo.st == 2) ? 1 : 0;
    e.due = due;
  endtask

  task automatic mreset();
    m0 = '{0, 0, 0, 0, 0};
    m1 = '{0, 0, 0, 0, 0};
  endtask

  // Drives one accepted frame; returns at T+1 (+1 time unit)
  task automatic accept_frame(input bit lst, input int x);
    mdl_t n;
    exp_t e;
    line_valid = 1'b1;
    line_lost = lst;
    centroid_x = 10'(x);
    @(posedge clk); #1;
    line_valid = 1'b0;
    line_lost = 1'($urandom_range(0, 1));
    centroid_x = 10'($urandom_range(0, 1023));
    mstep(m0, lst, x, 16, 8, cyc + 3, n, e);
    m0 = n; q0.push_back(e);
    mstep(m1, lst, x, 127, 0, cyc + 3, n, e);
    m1 = n; q1.push_back(e);
  endtask

  task automatic frame(input bit lst, input int x);
    accept_frame(lst, x);
    repeat (4 + $urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " dut0 steer_out"}, int'(so0), 0);
    chk({tag, " dut0 steer_valid"}, int'(sv0), 0);
    chk({tag, " dut0 mode"}, int'(md0), 0);
    chk({tag, " dut0 motor_en"}, int'(me0), 0);
    chk({tag, " dut0 busy"}, int'(bz0), 0);
    chk({tag, " dut0 overrun"}, int'(ov0), 0);
    chk({tag, " dut1 steer_out"}, int'(so1), 0);
    chk({tag, " dut1 mode"}, int'(md1), 0);
    chk({tag, " dut1 busy"}, int'(bz1), 0);
    chk({tag, " dut1 overrun"}, int'(ov1), 0);
  endtask

  always @(negedge clk) begin
    if (sv0) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected steer_valid at cycle", cyc, -1);
      end else begin
        p0 = q0.pop_front();
        chk("dut0 steer_out", int'(so0), p0.steer);
        chk("dut0 mode", int'(md0), p0.mode);
        chk("dut0 motor_en", int'(me0), p0.men);
        chk("dut0 latency cycle", cyc, p0.due);
        chk("dut0 busy at steer_valid", int'(bz0), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (sv1) begin
      if (q1.size() == 0) begin
        chk("dut1 unexpected steer_valid at cycle", cyc, -1);
      end else begin
        p1 = q1.pop_front();
        chk("dut1 steer_out", int'(so1), p1.steer);
        chk("dut1 mode", int'(md1), p1.mode);
        chk("dut1 motor_en", int'(me1), p1.men);
        chk("dut1 latency cycle", cyc, p1.due);
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle budget expired at %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    mreset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("reset");

    // acquire, then PD path
    repeat (3) frame(1'b0, 400);
    frame(1'b0, 400);
    frame(1'b0, 440);

    // lost sequence into SEARCH, then re-acquire
    repeat (8) frame(1'b1, $urandom_range(0, 639));
    repeat (3) frame(1'b0, 330);

    // saturation at both image edges
    frame(1'b0, 639);
    frame(1'b0, 0);
    frame(1'b0, 639);

    // randomized frames
    for (int i = 0; i < 120; i++) begin
      frame($urandom_range(0, 9) < 3,
            $urandom_range(0, 639));
    end

    // overrun: second strobe at accept+2 is dropped
    accept_frame(1'b0, 350);
    @(posedge clk); #1;
    line_valid = 1'b1;
    line_lost = 1'b0;
    centroid_x = 10'd100;
    @(posedge clk); #1;
    line_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dut0 overrun set", int'(ov0), 1);
    chk("dut1 overrun set", int'(ov1), 1);

    for (int i = 0; i < 40; i++) begin
      frame($urandom_range(0, 9) < 4,
            $urandom_range(0, 639));
    end
    chk("dut0 overrun sticky", int'(ov0), 1);
    chk("dut1 overrun sticky", int'(ov1), 1);

    // reset two cycles after an accept aborts it
    line_valid = 1'b1;
    line_lost = 1'b0;
    centroid_x = 10'd500;
    @(posedge clk); #1;
    line_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mreset();
    chk_reset("abort");
    repeat (8) @(posedge clk);
    #1;

    // strobe coincident with reset is ignored
    rst = 1'b1;
    line_valid = 1'b1;
    centroid_x = 10'd200;
    @(posedge clk); #1;
    rst = 1'b0;
    line_valid = 1'b0;
    chk("dut0 busy after rst+strobe", int'(bz0), 0);
    chk("dut1 busy after rst+strobe", int'(bz1), 0);
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      frame($urandom_range(0, 9) < 3,
            $urandom_range(0, 639));
    end

    repeat (10) @(posedge clk);
    #1;
    chk("dut0 pending results", q0.size(), 0);
    chk("dut1 pending results", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
